photon_gate_counter: RTL and testbench
======================================

Name: photon_gate_counter

Overview:
- Photon-counting stage directly downstream of the 16-bit command controller.
- Counts detector pulses inside a window opened by START_COUNT and closed by END_COUNT.
- Freezes the result, then returns it as two 16-bit words to the SPI transmit path when READ_DATA rises.
- Sits between the command controller (control inputs), the detector front-end (PHOTON_IN) and the SPI slave TX register (DATA_OUT handshake).

Parameters:
- CNT_WIDTH, 32, photon counter width; fixed at 32 for two-word readout.
- SYNC_STAGES, 2, flip-flop stages synchronising PHOTON_IN; legal values 2..4.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PHOTON_IN  in  1  asynchronous detector pulse; each rising edge is one photon.
- START_COUNT  in  1  level from controller; its rising edge opens a window.
- END_COUNT  in  1  level from controller; its rising edge closes the window.
- READ_DATA  in  1  level from controller; its rising edge requests readout.
- TX_READY  in  1  SPI TX can accept a word this cycle.
- DATA_OUT  out  16  readout word.
- DATA_VALID  out  1  DATA_OUT is valid; transfer when DATA_VALID & TX_READY.
- BUSY  out  1  high in COUNTING and READOUT states.
- OVERFLOW  out  1  sticky; counter saturated during the last window.

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; counter, DATA_OUT and sync/edge registers cleared; DATA_VALID=0, BUSY=0, OVERFLOW=0.
- Reset mid-window or mid-readout aborts the operation; the count is lost.
- PHOTON_IN path:
  - SYNC_STAGES-flop synchroniser, then a registered rising-edge detect producing a 1-cycle pulse.
  - The counter increments on the edge SYNC_STAGES+1 cycles after PHOTON_IN is first sampled high.
  - Pulse high time and low time must each be at least 1 CLK period; narrower pulses may be missed, and that is legal.
- Control inputs are synchronous levels. Each has a registered rising-edge detect; only edges act, so levels held high do not retrigger.
- States:
  - IDLE: START edge -> clear counter, clear OVERFLOW, go to COUNTING. END and READ edges ignored.
  - COUNTING:
    - Each photon pulse increments the counter by 1.
    - At 0xFFFF_FFFF the counter holds and OVERFLOW is set.
    - END edge -> HOLD. A photon pulse in the same cycle as the END edge is counted.
    - START and READ edges ignored.
  - HOLD:
    - Count frozen; photon pulses ignored.
    - READ edge -> load DATA_OUT = count[31:16], assert DATA_VALID, go to READOUT.
    - START edge -> restart exactly as from IDLE.
    - If READ and START edges occur in the same cycle, START wins.
  - READOUT:
    - DATA_OUT and DATA_VALID stay stable until the handshake (DATA_VALID & TX_READY).
    - High-word handshake: next cycle DATA_OUT = count[15:0], DATA_VALID stays 1.
    - Low-word handshake: DATA_VALID=0 next cycle, go to HOLD with count retained, so a later READ edge repeats the readout.
    - START, END and READ edges ignored; photon pulses ignored.
- BUSY is registered and equals (state == COUNTING || state == READOUT).
- OVERFLOW clears only on reset or on a START edge that is acted upon.
- TX_READY is honoured only while DATA_VALID=1.

Test Plan:
- Reset, START rise, 10 PHOTON_IN pulses (3 cycles high / 3 low), END rise, READ rise, TX_READY=1 -> words 0x0000 then 0x000A, each on one DATA_VALID cycle; BUSY back to 0; OVERFLOW=0.
- Force counter to 0xFFFF_FFFE via a hierarchical deposit, apply 3 pulses, END, READ -> words 0xFFFF, 0xFFFF; OVERFLOW=1; a following START rise clears OVERFLOW and the counter.
- Photon pulse edge detected in the same cycle as the END edge -> counted (expected low word 0x0001 with one pulse); a pulse 1 cycle after END -> not counted.
- During READOUT hold TX_READY=0 for 5 cycles -> DATA_OUT=0x0000 (high word) stable with DATA_VALID=1; raise TX_READY -> low word follows; a second READ rise from HOLD replays the same two words.
- START and READ held high continuously, END pulsed during COUNTING -> no retrigger or readout; in HOLD, simultaneous START and READ edges -> new COUNTING, no DATA_VALID.
- Assert RST_N=0 asynchronously mid-COUNTING (between clock edges) -> all outputs 0 immediately; after release, END and READ edges ignored in IDLE.

Source files
------------

// File: rtl/photon_gate_counter.sv
// photon_gate_counter
//   Counts synchronised detector pulses between a START_COUNT rising edge and
//   an END_COUNT rising edge. The frozen count is then returned as two 16-bit
//   words (high word first) to the SPI TX path when READ_DATA rises.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   PHOTON_IN       asynchronous detector pulse, one photon per rising edge
//   START_COUNT     control level, rising edge opens a counting window
//   END_COUNT       control level, rising edge closes the window
//   READ_DATA       control level, rising edge starts a two-word readout
//   TX_READY        SPI TX can take DATA_OUT this cycle
//   DATA_OUT        readout word
//   DATA_VALID      DATA_OUT valid; a word moves on DATA_VALID & TX_READY
//   BUSY            high while counting or reading out
//   OVERFLOW        sticky, counter saturated during the last window
module photon_gate_counter #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PHOTON_IN,
  input  logic        START_COUNT,
  input  logic        END_COUNT,
  input  logic        READ_DATA,
  input  logic        TX_READY,
  output logic [15:0] DATA_OUT,
  output logic        DATA_VALID,
  output logic        BUSY,
  output logic        OVERFLOW
);

  localparam int unsigned WORD_W = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTING,
    S_HOLD,
    S_READOUT
  } state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_low_sel;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ph_prev;
  logic                   r_ph_pulse;
  logic                   r_start_prev;
  logic                   r_end_prev;
  logic                   r_read_prev;

  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_count_nxt;
  logic                   w_low_sel_nxt;
  logic [WORD_W-1:0]      w_data_nxt;
  logic                   w_valid_nxt;
  logic                   w_busy_nxt;
  logic                   w_ovf_nxt;
  logic                   w_start_edge;
  logic                   w_end_edge;
  logic                   w_read_edge;
  logic                   w_handshake;

  // Photon synchroniser plus registered rising-edge detect (one-cycle pulse)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync     <= '0;
      r_ph_prev  <= 1'b0;
      r_ph_pulse <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], PHOTON_IN};
      r_ph_prev  <= r_sync[SYNC_STAGES-1];
      r_ph_pulse <= r_sync[SYNC_STAGES-1] & ~r_ph_prev;
    end
  end

  // Previous values of the control levels for edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_start_prev <= 1'b0;
      r_end_prev   <= 1'b0;
      r_read_prev  <= 1'b0;
    end else begin
      r_start_prev <= START_COUNT;
      r_end_prev   <= END_COUNT;
      r_read_prev  <= READ_DATA;
    end
  end

  assign w_start_edge = START_COUNT & ~r_start_prev;
  assign w_end_edge   = END_COUNT & ~r_end_prev;
  assign w_read_edge  = READ_DATA & ~r_read_prev;
  assign w_handshake  = DATA_VALID & TX_READY;

  // State, counter and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_low_sel  <= 1'b0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_low_sel  <= w_low_sel_nxt;
      DATA_OUT   <= w_data_nxt;
      DATA_VALID <= w_valid_nxt;
      BUSY       <= w_busy_nxt;
      OVERFLOW   <= w_ovf_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_low_sel_nxt = r_low_sel;
    w_data_nxt    = DATA_OUT;
    w_valid_nxt   = DATA_VALID;
    w_ovf_nxt     = OVERFLOW;

    unique case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_COUNTING;
        end
      end

      S_COUNTING: begin
        // Saturate rather than wrap; a pulse lost at full scale flags overflow
        if (r_ph_pulse) begin
          if (r_count == CNT_MAX) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_count_nxt = r_count + CNT_WIDTH'(1);
          end
        end
        if (w_end_edge) begin
          w_state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        // START takes priority over READ in the same cycle
        if (w_start_edge) begin
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_COUNTING;
        end else if (w_read_edge) begin
          w_data_nxt    = r_count[CNT_WIDTH-1 -: WORD_W];
          w_valid_nxt   = 1'b1;
          w_low_sel_nxt = 1'b0;
          w_state_nxt   = S_READOUT;
        end
      end

      S_READOUT: begin
        if (w_handshake) begin
          if (!r_low_sel) begin
            w_data_nxt    = r_count[WORD_W-1:0];
            w_low_sel_nxt = 1'b1;
          end else begin
            w_valid_nxt   = 1'b0;
            w_low_sel_nxt = 1'b0;
            w_state_nxt   = S_HOLD;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_COUNTING) || (w_state_nxt == S_READOUT);
  end

endmodule

// File: tb/tb_photon_gate_counter.sv
// Scoreboard bench for photon_gate_counter: stimulus pushes expected readout
// words, a negedge monitor pops and compares on every DATA_VALID & TX_READY.
module tb_photon_gate_counter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PHOTON_IN;
  logic        START_COUNT;
  logic        END_COUNT;
  logic        READ_DATA;
  logic        TX_READY;
  logic [15:0] DATA_OUT;
  logic        DATA_VALID;
  logic        BUSY;
  logic        OVERFLOW;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  photon_gate_counter #(
    .CNT_WIDTH   (32),
    .SYNC_STAGES (2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .PHOTON_IN   (PHOTON_IN),
    .START_COUNT (START_COUNT),
    .END_COUNT   (END_COUNT),
    .READ_DATA   (READ_DATA),
    .TX_READY    (TX_READY),
    .DATA_OUT    (DATA_OUT),
    .DATA_VALID  (DATA_VALID),
    .BUSY        (BUSY),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transferred word must match the head of the scoreboard
  always @(negedge CLK) begin
    if (RST_N && DATA_VALID && TX_READY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", DATA_OUT, $time);
      end else begin
        chk("readout_word", 32'(DATA_OUT), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_pulse();
    START_COUNT = 1'b1; tick(); tick();
    START_COUNT = 1'b0; tick();
  endtask

  task automatic end_pulse();
    END_COUNT = 1'b1; tick(); tick();
    END_COUNT = 1'b0; tick();
  endtask

  task automatic read_pulse();
    READ_DATA = 1'b1; tick(); tick();
    READ_DATA = 1'b0; tick();
  endtask

  // n photons, 3 cycles high / 3 low, then let the sync pipeline settle
  task automatic photons(input int n);
    repeat (n) begin
      PHOTON_IN = 1'b1; repeat (3) tick();
      PHOTON_IN = 1'b0; repeat (3) tick();
    end
    repeat (4) tick();
  endtask

  task automatic expect_words(input logic [15:0] hi, input logic [15:0] lo);
    sb.push_back(hi);
    sb.push_back(lo);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || DATA_VALID) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; PHOTON_IN = 1'b0; START_COUNT = 1'b0; END_COUNT = 1'b0;
    READ_DATA = 1'b0; TX_READY = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_valid", 32'(DATA_VALID), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_data", 32'(DATA_OUT), 32'd0);
    RST_N = 1'b1;
    tick();

    // Basic window of 10 photons
    start_pulse();
    chk("t1_busy_counting", 32'(BUSY), 32'd1);
    photons(10);
    end_pulse();
    chk("t1_busy_hold", 32'(BUSY), 32'd0);
    expect_words(16'h0000, 16'h000A);
    read_pulse();
    wait_drain("t1");
    chk("t1_busy_end", 32'(BUSY), 32'd0);
    chk("t1_ovf", 32'(OVERFLOW), 32'd0);

    // Saturation from a deposited near-full count
    start_pulse();
    dut.r_count <= 32'hFFFF_FFFE;
    tick();
    photons(3);
    chk("t2_ovf_counting", 32'(OVERFLOW), 32'd1);
    end_pulse();
    expect_words(16'hFFFF, 16'hFFFF);
    read_pulse();
    wait_drain("t2");
    chk("t2_ovf_hold", 32'(OVERFLOW), 32'd1);
    start_pulse();
    chk("t2_ovf_cleared", 32'(OVERFLOW), 32'd0);
    end_pulse();
    expect_words(16'h0000, 16'h0000);
    read_pulse();
    wait_drain("t2b");

    // Photon pulse in the same cycle as the END edge is counted
    start_pulse();
    PHOTON_IN = 1'b1; tick(); tick(); tick();
    END_COUNT = 1'b1; PHOTON_IN = 1'b0; tick(); tick();
    END_COUNT = 1'b0; repeat (5) tick();
    expect_words(16'h0000, 16'h0001);
    read_pulse();
    wait_drain("t3a");

    // Photon pulse one cycle after the END edge is not counted
    start_pulse();
    PHOTON_IN = 1'b1; tick(); tick();
    END_COUNT = 1'b1; tick();
    PHOTON_IN = 1'b0; tick();
    END_COUNT = 1'b0; repeat (5) tick();
    expect_words(16'h0000, 16'h0000);
    read_pulse();
    wait_drain("t3b");

    // Back-pressure: high word held stable, then replay from HOLD
    start_pulse();
    photons(5);
    end_pulse();
    TX_READY = 1'b0;
    READ_DATA = 1'b1; tick();
    READ_DATA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid_stall", 32'(DATA_VALID), 32'd1);
      chk("t4_data_stall", 32'(DATA_OUT), 32'h0000);
      tick();
    end
    expect_words(16'h0000, 16'h0005);
    TX_READY = 1'b1;
    wait_drain("t4");
    expect_words(16'h0000, 16'h0005);
    read_pulse();
    wait_drain("t4b");

    // Held START/READ levels do not retrigger; START beats READ in HOLD
    START_COUNT = 1'b1; tick(); tick();
    chk("t5_busy_start", 32'(BUSY), 32'd1);
    READ_DATA = 1'b1; tick(); tick();
    end_pulse();
    for (int i = 0; i < 3; i++) begin
      chk("t5_busy_hold", 32'(BUSY), 32'd0);
      chk("t5_no_valid", 32'(DATA_VALID), 32'd0);
      tick();
    end
    START_COUNT = 1'b0; READ_DATA = 1'b0; tick();
    START_COUNT = 1'b1; READ_DATA = 1'b1; tick();
    chk("t5_restart_busy", 32'(BUSY), 32'd1);
    chk("t5_restart_valid", 32'(DATA_VALID), 32'd0);
    tick();
    chk("t5_restart_valid2", 32'(DATA_VALID), 32'd0);
    START_COUNT = 1'b0; READ_DATA = 1'b0;

    // Asynchronous reset mid-window clears outputs immediately
    tick();
    #3;
    RST_N = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    chk("t6_rst_valid", 32'(DATA_VALID), 32'd0);
    chk("t6_rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("t6_rst_data", 32'(DATA_OUT), 32'd0);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    end_pulse();
    read_pulse();
    for (int i = 0; i < 3; i++) begin
      chk("t6_idle_busy", 32'(BUSY), 32'd0);
      chk("t6_idle_valid", 32'(DATA_VALID), 32'd0);
      tick();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
